// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared state and grant encodings for the two-master Wishbone arbiter.
package wb_arb_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_e;
    typedef enum logic [1:0] {
        GNT_NONE = 2'b00,
        GNT_M0   = 2'b01,
        GNT_M1   = 2'b10
    } grant_e;
endpackage

// File: rtl/wb_arb_watchdog.sv
// wb_arb_watchdog: counts consecutive stalled strobe cycles and flags expiry at TIMEOUT_CYCLES.
module wb_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic expire
);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // Saturates at LIMIT so a long stall can never wrap back below it.
    always_comb cnt_d = clear ? '0 : (enable && cnt_q != LIMIT) ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk or posedge reset)
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    assign expire = (TIMEOUT_CYCLES != 0) && (cnt_q == LIMIT);
endmodule

// File: rtl/wb_arbiter2.sv
// wb_arbiter2: round-robin two-master to one-slave Wishbone classic arbiter
// with grant held for a whole CYC and a stall watchdog that errors the owner.
module wb_arbiter2
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_m0_wb_adr,
    input  logic [31:0] i_m0_wb_dat,
    input  logic [3:0]  i_m0_wb_sel,
    input  logic        i_m0_wb_we,
    input  logic        i_m0_wb_cyc,
    input  logic        i_m0_wb_stb,
    output logic [31:0] o_m0_wb_dat,
    output logic        o_m0_wb_ack,
    output logic        o_m0_wb_err,
    input  logic [31:0] i_m1_wb_adr,
    input  logic [31:0] i_m1_wb_dat,
    input  logic [3:0]  i_m1_wb_sel,
    input  logic        i_m1_wb_we,
    input  logic        i_m1_wb_cyc,
    input  logic        i_m1_wb_stb,
    output logic [31:0] o_m1_wb_dat,
    output logic        o_m1_wb_ack,
    output logic        o_m1_wb_err,
    output logic [31:0] o_s_wb_adr,
    output logic [31:0] o_s_wb_dat,
    output logic [3:0]  o_s_wb_sel,
    output logic        o_s_wb_we,
    output logic        o_s_wb_cyc,
    output logic        o_s_wb_stb,
    input  logic [31:0] i_s_wb_dat,
    input  logic        i_s_wb_ack,
    output logic [1:0]  o_grant
);
    state_e state_q, state_d;
    grant_e grant_q, grant_d, last_q, last_d, pick;
    logic   own0, own1, m_cyc, m_stb, stall, expire, tmo;

    assign own0  = grant_q == GNT_M0;
    assign own1  = grant_q == GNT_M1;
    assign m_cyc = own0 ? i_m0_wb_cyc : own1 ? i_m1_wb_cyc : 1'b0;
    assign m_stb = own0 ? i_m0_wb_stb : own1 ? i_m1_wb_stb : 1'b0;

    assign o_s_wb_cyc = (state_q == BUSY) & m_cyc;
    assign o_s_wb_stb = o_s_wb_cyc & m_stb;
    assign o_s_wb_adr = own0 ? i_m0_wb_adr : own1 ? i_m1_wb_adr : '0;
    assign o_s_wb_dat = own0 ? i_m0_wb_dat : own1 ? i_m1_wb_dat : '0;
    assign o_s_wb_sel = own0 ? i_m0_wb_sel : own1 ? i_m1_wb_sel : '0;
    assign o_s_wb_we  = own0 ? i_m0_wb_we  : own1 ? i_m1_wb_we  : 1'b0;

    assign o_m0_wb_dat = i_s_wb_dat;
    assign o_m1_wb_dat = i_s_wb_dat;
    // Acks only pass while the owner still holds CYC, so late acks are dropped.
    assign o_m0_wb_ack = o_s_wb_cyc & own0 & i_s_wb_ack;
    assign o_m1_wb_ack = o_s_wb_cyc & own1 & i_s_wb_ack;

    assign stall       = o_s_wb_stb & ~i_s_wb_ack;
    assign tmo         = stall & expire;
    assign o_m0_wb_err = tmo & own0;
    assign o_m1_wb_err = tmo & own1;
    assign o_grant     = grant_q;

    wb_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_wdog (
        .clk   (i_clk),
        .reset (i_reset),
        .enable(stall),
        .clear (i_s_wb_ack | ~o_s_wb_stb),
        .expire(expire)
    );

    // On a tie the master that did not own the bus last wins.
    assign pick = (i_m0_wb_cyc & i_m1_wb_cyc) ? ((last_q == GNT_M0) ? GNT_M1 : GNT_M0)
                : i_m0_wb_cyc ? GNT_M0 : GNT_M1;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        if (state_q == IDLE) begin
            if (i_m0_wb_cyc | i_m1_wb_cyc) begin
                state_d = BUSY;
                grant_d = pick;
            end
        end else if (!m_cyc) begin
            state_d = IDLE;
            grant_d = GNT_NONE;
            last_d  = grant_q;
        end else if (tmo) begin
            state_d = DRAIN;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset)
        if (i_reset) begin
            state_q <= IDLE;
            grant_q <= GNT_NONE;
            last_q  <= GNT_M1;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
endmodule

// File: tb/tb_wb_arbiter2.sv
// tb_wb_arbiter2: vector table, directed corner sequences and randomized traffic against a reference model.
module tb_wb_arbiter2;
    localparam int TMO = 4;

    logic        clk = 1'b0, rst;
    logic [31:0] adr0, adr1, dat0, dat1, sdat;
    logic [3:0]  sel0, sel1;
    logic        we0, we1, cyc0, cyc1, stb0, stb1, sack;
    logic [31:0] mdat0, mdat1, s_adr, s_dat;
    logic [3:0]  s_sel;
    logic        ack0, ack1, err0, err1, s_we, s_cyc, s_stb;
    logic [1:0]  gnt;

    int n_chk = 0, n_fail = 0;
    int own, last, stalls;
    bit drain;

    always #5 clk = ~clk;

    wb_arbiter2 #(.TIMEOUT_CYCLES(TMO), .CNT_W(8)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_m0_wb_adr(adr0), .i_m0_wb_dat(dat0), .i_m0_wb_sel(sel0), .i_m0_wb_we(we0),
        .i_m0_wb_cyc(cyc0), .i_m0_wb_stb(stb0),
        .o_m0_wb_dat(mdat0), .o_m0_wb_ack(ack0), .o_m0_wb_err(err0),
        .i_m1_wb_adr(adr1), .i_m1_wb_dat(dat1), .i_m1_wb_sel(sel1), .i_m1_wb_we(we1),
        .i_m1_wb_cyc(cyc1), .i_m1_wb_stb(stb1),
        .o_m1_wb_dat(mdat1), .o_m1_wb_ack(ack1), .o_m1_wb_err(err1),
        .o_s_wb_adr(s_adr), .o_s_wb_dat(s_dat), .o_s_wb_sel(s_sel), .o_s_wb_we(s_we),
        .o_s_wb_cyc(s_cyc), .o_s_wb_stb(s_stb),
        .i_s_wb_dat(sdat), .i_s_wb_ack(sack), .o_grant(gnt)
    );

    typedef struct {
        bit       rst;
        bit [1:0] cyc;
        bit       ack;
        bit [1:0] gnt;
        bit       sstb;
        bit [1:0] eack;
    } vec_t;
    vec_t tv [25];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit c0, input bit s0, input bit c1, input bit s1, input bit a);
        cyc0 = c0; stb0 = s0; cyc1 = c1; stb1 = s1; sack = a;
    endtask

    task automatic look(input string t, input logic [1:0] g, input logic sc, input logic ss,
                        input logic [1:0] a, input logic [1:0] e);
        chk({t, " grant"}, 32'(gnt), 32'(g));
        chk({t, " s_cyc"}, 32'(s_cyc), 32'(sc));
        chk({t, " s_stb"}, 32'(s_stb), 32'(ss));
        chk({t, " ack"}, 32'({ack1, ack0}), 32'(a));
        chk({t, " err"}, 32'({err1, err0}), 32'(e));
    endtask

    task automatic chk_bus(input string t, input int m);
        chk({t, " s_adr"}, s_adr, m == 0 ? adr0 : adr1);
        chk({t, " s_dat"}, s_dat, m == 0 ? dat0 : dat1);
        chk({t, " s_sel"}, 32'(s_sel), 32'(m == 0 ? sel0 : sel1));
        chk({t, " s_we"}, 32'(s_we), 32'(m == 0 ? we0 : we1));
    endtask

    task automatic do_reset(input string t);
        drive(0, 0, 0, 0, 0);
        rst = 1'b1;
        #2;
        look(t, 2'b00, 0, 0, 2'b00, 2'b00);
        tick();
        rst = 1'b0;
        own = -1; last = 1; stalls = 0; drain = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bit       r;
        bit [1:0] c, s, e_g, e_a, e_e;
        bit       e_sc, e_ss;
        tv = '{
            '{0, 2'b01, 0, 2'b00, 0, 2'b00}, '{0, 2'b01, 0, 2'b01, 1, 2'b00},
            '{0, 2'b01, 1, 2'b01, 1, 2'b01}, '{0, 2'b00, 0, 2'b01, 0, 2'b00},
            '{0, 2'b00, 0, 2'b00, 0, 2'b00}, '{1, 2'b00, 0, 2'b00, 0, 2'b00},
            '{0, 2'b11, 0, 2'b00, 0, 2'b00}, '{0, 2'b11, 0, 2'b01, 1, 2'b00},
            '{0, 2'b11, 1, 2'b01, 1, 2'b01}, '{0, 2'b10, 0, 2'b01, 0, 2'b00},
            '{0, 2'b10, 0, 2'b00, 0, 2'b00}, '{0, 2'b10, 0, 2'b10, 1, 2'b00},
            '{0, 2'b11, 1, 2'b10, 1, 2'b10}, '{0, 2'b01, 0, 2'b10, 0, 2'b00},
            '{0, 2'b01, 0, 2'b00, 0, 2'b00}, '{0, 2'b01, 0, 2'b01, 1, 2'b00},
            '{0, 2'b00, 0, 2'b01, 0, 2'b00}, '{0, 2'b00, 0, 2'b00, 0, 2'b00},
            '{0, 2'b01, 0, 2'b00, 0, 2'b00}, '{0, 2'b01, 0, 2'b01, 1, 2'b00},
            '{1, 2'b01, 0, 2'b00, 0, 2'b00}, '{0, 2'b11, 0, 2'b00, 0, 2'b00},
            '{0, 2'b11, 0, 2'b01, 1, 2'b00}, '{0, 2'b00, 0, 2'b01, 0, 2'b00},
            '{0, 2'b00, 0, 2'b00, 0, 2'b00}
        };
        adr0 = 32'h0;   dat0 = 32'h0000_00A5; sel0 = 4'hF; we0 = 1'b1;
        adr1 = 32'h100; dat1 = 32'h0000_5A5A; sel1 = 4'h3; we1 = 1'b0;
        sdat = 32'h0;
        rst  = 1'b1;
        drive(0, 0, 0, 0, 0);
        #2;
        look("por", 2'b00, 0, 0, 2'b00, 2'b00);
        tick();
        tick();
        rst = 1'b0;

        for (int i = 0; i < 25; i++) begin
            rst  = tv[i].rst;
            sdat = 32'hCAFE_0000 + 32'(i);
            drive(tv[i].cyc[0], tv[i].cyc[0], tv[i].cyc[1], tv[i].cyc[1], tv[i].ack);
            #2;
            look($sformatf("vec%0d", i), tv[i].gnt, tv[i].sstb, tv[i].sstb, tv[i].eack, 2'b00);
            chk($sformatf("vec%0d m0_dat", i), mdat0, sdat);
            chk($sformatf("vec%0d m1_dat", i), mdat1, sdat);
            if (tv[i].sstb) chk_bus($sformatf("vec%0d", i), tv[i].gnt == 2'b01 ? 0 : 1);
            tick();
        end
        rst = 1'b0;

        do_reset("rstA");
        drive(0, 0, 1, 1, 0); #2; look("b2b idle", 2'b00, 0, 0, 2'b00, 2'b00); tick();
        drive(1, 1, 1, 1, 0); #2; look("b2b own", 2'b10, 1, 1, 2'b00, 2'b00); tick();
        for (int k = 0; k < 3; k++) begin
            sack = 1'b0; #2; look($sformatf("b2b wait%0d", k), 2'b10, 1, 1, 2'b00, 2'b00); tick();
            sack = 1'b1; #2; look($sformatf("b2b rd%0d", k), 2'b10, 1, 1, 2'b10, 2'b00);
            chk_bus($sformatf("b2b rd%0d", k), 1);
            tick();
        end
        drive(1, 1, 0, 0, 0); #2; look("b2b rel", 2'b10, 0, 0, 2'b00, 2'b00); tick();
        #2; look("b2b gap", 2'b00, 0, 0, 2'b00, 2'b00); tick();
        #2; look("b2b m0", 2'b01, 1, 1, 2'b00, 2'b00); tick();
        drive(0, 0, 0, 0, 0); tick(); tick();

        do_reset("rstB");
        drive(1, 1, 0, 0, 0); #2; look("wd idle", 2'b00, 0, 0, 2'b00, 2'b00); tick();
        for (int k = 0; k < TMO; k++) begin
            #2; look($sformatf("wd stall%0d", k), 2'b01, 1, 1, 2'b00, 2'b00); tick();
            drive(1, 1, 1, 1, 0);
        end
        #2; look("wd expire", 2'b01, 1, 1, 2'b00, 2'b01); tick();
        sack = 1'b1; #2; look("wd drain", 2'b01, 0, 0, 2'b00, 2'b00); tick();
        drive(0, 0, 1, 1, 0); #2; look("wd release", 2'b01, 0, 0, 2'b00, 2'b00); tick();
        #2; look("wd gap", 2'b00, 0, 0, 2'b00, 2'b00); tick();
        #2; look("wd m1", 2'b10, 1, 1, 2'b00, 2'b00); tick();
        drive(0, 0, 0, 0, 0); tick(); tick();

        do_reset("rstC");
        drive(1, 1, 0, 0, 0); #2; look("race idle", 2'b00, 0, 0, 2'b00, 2'b00); tick();
        for (int k = 0; k < TMO; k++) begin
            #2; look($sformatf("race stall%0d", k), 2'b01, 1, 1, 2'b00, 2'b00); tick();
        end
        sack = 1'b1; #2; look("race ack", 2'b01, 1, 1, 2'b01, 2'b00); tick();
        sack = 1'b0; #2; look("race after", 2'b01, 1, 1, 2'b00, 2'b00); tick();
        drive(0, 0, 0, 0, 0); #2; look("race rel", 2'b01, 0, 0, 2'b00, 2'b00); tick(); tick();

        do_reset("rstR");
        for (int n = 0; n < 3000; n++) begin
            r = ($urandom_range(199) == 0);
            c[0] = cyc0 ? ($urandom_range(5) != 0) : ($urandom_range(2) == 0);
            c[1] = cyc1 ? ($urandom_range(5) != 0) : ($urandom_range(2) == 0);
            s[0] = c[0] & ($urandom_range(3) != 0);
            s[1] = c[1] & ($urandom_range(3) != 0);
            rst  = r;
            adr0 = $urandom; adr1 = $urandom; dat0 = $urandom; dat1 = $urandom;
            sel0 = 4'($urandom); sel1 = 4'($urandom); we0 = 1'($urandom); we1 = 1'($urandom);
            sdat = $urandom;
            drive(c[0], s[0], c[1], s[1], $urandom_range(2) == 0);
            e_g = 2'b00; e_sc = 1'b0; e_ss = 1'b0; e_a = 2'b00; e_e = 2'b00;
            if (!r && own >= 0) begin
                e_g = (own == 0) ? 2'b01 : 2'b10;
                if (!drain && c[own]) begin
                    e_sc = 1'b1;
                    e_ss = s[own];
                end
                if (e_sc && sack) e_a = e_g;
                if (e_ss && !sack && stalls == TMO) e_e = e_g;
            end
            #2;
            look($sformatf("rnd%0d", n), e_g, e_sc, e_ss, e_a, e_e);
            chk($sformatf("rnd%0d m0_dat", n), mdat0, sdat);
            if (e_sc) chk_bus($sformatf("rnd%0d", n), own);
            tick();
            if (r) begin
                own = -1; last = 1; stalls = 0; drain = 0;
            end else if (own < 0) begin
                if (c != 2'b00) own = (c == 2'b11) ? 1 - last : (c[0] ? 0 : 1);
            end else if (!c[own]) begin
                last = own; own = -1; drain = 0; stalls = 0;
            end else if (!drain) begin
                if (e_e != 2'b00) drain = 1'b1;
                else stalls = (e_ss && !sack) ? (stalls < TMO ? stalls + 1 : TMO) : 0;
            end
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_arbiter2.md
Name: wb_arbiter2

Overview:
Two-master to one-slave Wishbone classic arbiter. It shares a single peripheral slave port, such as the LED register block, between two requesters, for example the management-core bus and a user-side sequencer. Arbitration is round-robin, and a grant is held for the whole of a master's cycle (CYC high). A bus watchdog terminates slave accesses that are never acknowledged.

Parameters:
TIMEOUT_CYCLES, 255, consecutive stalled strobe cycles before the watchdog fires; 0 disables the watchdog.
CNT_W, 8, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
i_clk  in  1  system clock
i_reset  in  1  asynchronous, active-high reset
i_m0_wb_adr / i_m1_wb_adr  in  32 each  master address
i_m0_wb_dat / i_m1_wb_dat  in  32 each  master write data
i_m0_wb_sel / i_m1_wb_sel  in  4 each  byte selects
i_m0_wb_we / i_m1_wb_we  in  1 each  write enable
i_m0_wb_cyc / i_m1_wb_cyc  in  1 each  cycle (bus request)
i_m0_wb_stb / i_m1_wb_stb  in  1 each  strobe
o_m0_wb_dat / o_m1_wb_dat  out  32 each  read data
o_m0_wb_ack / o_m1_wb_ack  out  1 each  acknowledge
o_m0_wb_err / o_m1_wb_err  out  1 each  watchdog error, one-cycle pulse
o_s_wb_adr, o_s_wb_dat  out  32 each  to slave
o_s_wb_sel  out  4  to slave
o_s_wb_we, o_s_wb_cyc, o_s_wb_stb  out  1 each  to slave
i_s_wb_dat  in  32  slave read data
i_s_wb_ack  in  1  slave acknowledge
o_grant  out  2  one-hot current owner: 01 = m0, 10 = m1, 00 = none

Behaviour:
- Reset is asynchronous and active-high and may be asserted at any time, including mid-transaction. On reset:
  - state = IDLE, grant = none, last = m1 (so m0 wins the first tie), watchdog counter = 0.
  - All outputs go to 0 immediately: acks, errs, o_s_wb_cyc, o_s_wb_stb.
- States: IDLE, BUSY, DRAIN.
- IDLE:
  - Slave CYC/STB are driven 0.
  - If exactly one master has CYC=1, it is granted at the next clock edge.
  - If both have CYC=1, the master that is not `last` is granted.
  - Next state is BUSY. Arbitration costs 1 cycle: the slave sees STB one cycle after the master raises CYC.
- BUSY:
  - Slave adr/dat/sel/we/cyc/stb are a combinational mux of the granted master's signals.
  - i_s_wb_ack is routed only to the granted master; the other master's ack is 0.
  - i_s_wb_dat is forwarded to both o_mX_wb_dat.
  - The non-granted master is stalled (no ack) for as long as it holds CYC.
  - When the granted master drops CYC: last <= grant, grant <= none, state -> IDLE. There is always one idle cycle between owners.
  - Back-to-back accesses under a single CYC stay with the same owner. No preemption.
- Watchdog:
  - The counter increments each BUSY cycle with o_s_wb_stb=1 and i_s_wb_ack=0, and clears on ack or when STB is low.
  - When the counter reaches TIMEOUT_CYCLES and ack is still 0: pulse the owner's o_mX_wb_err for 1 cycle, state -> DRAIN.
  - An ack arriving in the same cycle as the expiry takes precedence: no err.
- DRAIN:
  - Slave CYC/STB are forced to 0 and any late slave ack is discarded.
  - When the owner drops CYC: last <= grant, state -> IDLE.
- If a master drops CYC while its strobe is outstanding, the arbiter releases immediately and any later ack is dropped.
- The watchdog counter saturates and never wraps.

Decomposition:
- Shared package wb_arb_pkg: state encoding (IDLE/BUSY/DRAIN), grant encodings (GNT_NONE/GNT_M0/GNT_M1).
- One sub-module, wb_arb_watchdog: inputs clk, reset, enable (BUSY & stb & ~ack), clear; output expire. Parameterised by TIMEOUT_CYCLES and CNT_W.
- Muxing and the FSM live in the top level.

Test Plan:
- m0 only, write 0x000000A5 to adr 0x0 → slave sees STB one cycle after CYC, adr 0x0, dat 0xA5, sel 0xF; m0 gets ack; o_m1_wb_ack stays 0; o_grant = 01 then 00.
- m0 and m1 raise CYC in the same cycle after reset → m0 is granted first; after m0 drops CYC and one idle cycle, m1 is granted. Repeat the contention → m0 and m1 alternate.
- m1 owns the bus and performs 3 back-to-back reads while m0 requests → all 3 reads complete for m1 with the same grant; m0 is granted only after m1's CYC falls.
- TIMEOUT_CYCLES=4, slave never acks m0 → o_m0_wb_err pulses 1 cycle after 4 stalled cycles; slave CYC/STB fall; a late ack is not forwarded; a pending m1 request is granted after m0 drops CYC.
- Slave ack arrives in the same cycle the counter reaches 4 → ack is delivered, no err.
- Assert i_reset during a BUSY cycle with STB high → all outputs are 0 in the same cycle; after release, the first tie goes to m0.
